// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Stall/flush sequencer for a 5-stage (IF/ID/EX/ME/WB) RISC-V pipeline.
//   It combines the load-use stall, ID-stage branch redirect, I/D-cache miss
//   freeze and multi-cycle mul/div EX occupancy into per-stage register
//   enables and bubble controls. It also keeps saturating hazard counters.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   load_use_hazard   ID needs a result that is still in EX
//   branch_taken      branch/jump resolved taken in ID
//   muldiv_start      EX holds a mul/div instruction
//   icache_stall      I-cache miss outstanding
//   dcache_stall      D-cache miss outstanding
//   pc_en .. me_wb_en per-stage register load enables
//   *_flush           load a bubble into that stage register (only when it is enabled)
//   md_busy, md_done  mul/div occupying EX / final release cycle
//   stall_cnt         cycles with pc_en=0, saturating
//   flush_cnt         cycles with if_id_flush=1, saturating

module pipe_hazard_sat_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               cnt <= '0;
    else if (inc && !(&cnt))  cnt <= cnt + 1'b1;
  end
endmodule

module pipe_hazard_ctrl #(
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use_hazard,
  input  logic             branch_taken,
  input  logic             muldiv_start,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_me_en,
  output logic             me_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_me_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int MW = $clog2(MD_LAT);
  localparam int NCNT = 2;

  typedef enum logic {RUN, BUSY} state_t;

  typedef struct packed {
    logic pc;
    logic if_id;
    logic id_ex;
    logic ex_me;
    logic me_wb;
  } en_t;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_me;
  } flush_t;

  state_t  state, state_nxt;
  logic [MW-1:0] md_cnt, md_cnt_nxt;
  en_t     en;
  flush_t  fl;
  logic    cache, md_hold, md_rel;

  assign cache   = icache_stall | dcache_stall;
  assign md_hold = (state == BUSY) && (md_cnt > MW'(1));
  assign md_rel  = (state == BUSY) && (md_cnt == MW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RUN;
      md_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
    end
  end

  always_comb begin
    en         = '1;
    fl         = '0;
    md_busy    = (state == BUSY);
    md_done    = 1'b0;
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    if (cache) begin
      // Whole pipe frozen; hazard inputs stay asserted upstream and are
      // re-evaluated once the miss clears.
      en = '0;
    end else if (md_hold) begin
      // Op stays in EX: ID and younger hold, EX/ME takes bubbles.
      en.pc      = 1'b0;
      en.if_id   = 1'b0;
      en.id_ex   = 1'b0;
      fl.ex_me   = 1'b1;
      md_cnt_nxt = md_cnt - 1'b1;
    end else begin
      if (md_rel) begin
        // EX result moves on; ID side is handled by the RUN rules below.
        // muldiv_start is still high for this op, so no restart here.
        md_done    = 1'b1;
        state_nxt  = RUN;
        md_cnt_nxt = '0;
      end
      if (load_use_hazard) begin
        // Branch is suppressed; it re-resolves next cycle with good operands.
        en.pc    = 1'b0;
        en.if_id = 1'b0;
        fl.id_ex = 1'b1;
      end else if (state == RUN && muldiv_start) begin
        en.pc      = 1'b0;
        en.if_id   = 1'b0;
        en.id_ex   = 1'b0;
        fl.ex_me   = 1'b1;
        state_nxt  = BUSY;
        md_cnt_nxt = MW'(MD_LAT - 1);
      end else if (branch_taken) begin
        fl.if_id = 1'b1;
      end
    end
  end

  assign pc_en       = en.pc;
  assign if_id_en    = en.if_id;
  assign id_ex_en    = en.id_ex;
  assign ex_me_en    = en.ex_me;
  assign me_wb_en    = en.me_wb;
  assign if_id_flush = fl.if_id;
  assign id_ex_flush = fl.id_ex;
  assign ex_me_flush = fl.ex_me;

  // Performance counters: [0] stall cycles, [1] IF/ID flush cycles.
  logic [NCNT-1:0]            cnt_inc;
  logic [NCNT-1:0][CNT_W-1:0] cnt_val;

  assign cnt_inc = {fl.if_id, ~en.pc};

  for (genvar g = 0; g < NCNT; g++) begin : g_cnt
    pipe_hazard_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (cnt_inc[g]),
      .cnt   (cnt_val[g])
    );
  end

  assign stall_cnt = cnt_val[0];
  assign flush_cnt = cnt_val[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl (MD_LAT=4, CNT_W=4 so saturation is reachable).
module tb_pipe_hazard_ctrl;
  localparam int MD_LAT = 4;
  localparam int CNT_W  = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic lu = 0, br = 0, md = 0, ic = 0, dc = 0;
  logic pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en;
  logic if_id_flush, id_ex_flush, ex_me_flush, md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .load_use_hazard(lu), .branch_taken(br), .muldiv_start(md),
    .icache_stall(ic), .dcache_stall(dc),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
    .ex_me_en(ex_me_en), .me_wb_en(me_wb_en),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_me_flush(ex_me_flush),
    .md_busy(md_busy), .md_done(md_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // input order {lu, br, md, ic, dc}
  localparam logic [4:0] I0 = 5'b00000, LU = 5'b10000, BR = 5'b01000,
                         MD = 5'b00100, IC = 5'b00010, DC = 5'b00001;
  // enable order {pc, if_id, id_ex, ex_me, me_wb}
  localparam logic [4:0] EA = 5'b11111, EM = 5'b00011, EL = 5'b00111, EN = 5'b00000;
  // flush order {if_id, id_ex, ex_me}
  localparam logic [2:0] F0 = 3'b000, FI = 3'b100, FD = 3'b010, FX = 3'b001;

  typedef struct {
    string      n;
    logic [4:0] in;
    logic [4:0] en;
    logic [2:0] fl;
    logic       b, d;
  } vec_t;

  typedef struct {
    string            n;
    logic [4:0]       en;
    logic [2:0]       fl;
    logic             b, d;
    logic [CNT_W-1:0] sc, fc;
  } exp_t;

  exp_t sb[$];
  int total = 0, bad = 0;
  logic [CNT_W-1:0] m_sc = '0, m_fc = '0;
  localparam logic [CNT_W-1:0] CMAX = '1;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Drive one cycle of inputs and queue what the DUT must show this cycle.
  task automatic step(string n, logic [4:0] in, logic [4:0] en, logic [2:0] fl,
                      logic b, logic d);
    exp_t e;
    @(posedge clk); #1;
    {lu, br, md, ic, dc} = in;
    e.n = n; e.en = en; e.fl = fl; e.b = b; e.d = d; e.sc = m_sc; e.fc = m_fc;
    sb.push_back(e);
    if (!en[4] && m_sc != CMAX) m_sc++;
    if (fl[2]  && m_fc != CMAX) m_fc++;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk({e.n, ".en"},   32'({pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en}), 32'(e.en));
      chk({e.n, ".fl"},   32'({if_id_flush, id_ex_flush, ex_me_flush}), 32'(e.fl));
      chk({e.n, ".busy"}, 32'(md_busy), 32'(e.b));
      chk({e.n, ".done"}, 32'(md_done), 32'(e.d));
      chk({e.n, ".scnt"}, 32'(stall_cnt), 32'(e.sc));
      chk({e.n, ".fcnt"}, 32'(flush_cnt), 32'(e.fc));
    end
  end

  task automatic chk_reset_state(string n);
    chk({n, ".en"},   32'({pc_en, if_id_en, id_ex_en, ex_me_en, me_wb_en}), 32'(EA));
    chk({n, ".fl"},   32'({if_id_flush, id_ex_flush, ex_me_flush}), 32'(F0));
    chk({n, ".busy"}, 32'(md_busy), 0);
    chk({n, ".done"}, 32'(md_done), 0);
    chk({n, ".scnt"}, 32'(stall_cnt), 0);
    chk({n, ".fcnt"}, 32'(flush_cnt), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    tbl.push_back('{"lu",        LU,         EL, FD, 0, 0});
    tbl.push_back('{"lu_gone",   I0,         EA, F0, 0, 0});
    tbl.push_back('{"md_start",  MD,         EM, FX, 0, 0});
    tbl.push_back('{"md_b3",     MD,         EM, FX, 1, 0});
    tbl.push_back('{"md_b2_ign", MD|BR|LU,   EM, FX, 1, 0});
    tbl.push_back('{"md_rel",    MD,         EA, F0, 1, 1});
    tbl.push_back('{"run",       I0,         EA, F0, 0, 0});
    tbl.push_back('{"br_lu",     BR|LU,      EL, FD, 0, 0});
    tbl.push_back('{"br_only",   BR,         EA, FI, 0, 0});
    tbl.push_back('{"ic_stall",  IC|BR|LU,   EN, F0, 0, 0});
    tbl.push_back('{"idle",      I0,         EA, F0, 0, 0});
    tbl.push_back('{"m2_start",  MD,         EM, FX, 0, 0});
    tbl.push_back('{"m2_b3",     I0,         EM, FX, 1, 0});
    for (int k = 0; k < 5; k++)
      tbl.push_back('{"m2_dc",   DC|LU,      EN, F0, 1, 0});
    tbl.push_back('{"m2_b2",     I0,         EM, FX, 1, 0});
    tbl.push_back('{"m2_rel_lu", LU|MD,      EL, FD, 1, 1});
    tbl.push_back('{"post",      I0,         EA, F0, 0, 0});
    tbl.push_back('{"m3_start",  MD|BR,      EM, FX, 0, 0});
    tbl.push_back('{"m3_b3",     I0,         EM, FX, 1, 0});
    tbl.push_back('{"m3_b2",     I0,         EM, FX, 1, 0});
    tbl.push_back('{"m3_rel_br", BR,         EA, FI, 1, 1});
    tbl.push_back('{"idle2",     I0,         EA, F0, 0, 0});

    // reset state
    #12;
    chk_reset_state("rst");
    @(negedge clk); rst_n = 1'b1;

    for (int k = 0; k < 10; k++) step("idle0", I0, EA, F0, 0, 0);
    foreach (tbl[k]) step(tbl[k].n, tbl[k].in, tbl[k].en, tbl[k].fl, tbl[k].b, tbl[k].d);

    // reset in the middle of a mul/div op
    step("m4_start", MD, EM, FX, 0, 0);
    step("m4_b3",    I0, EM, FX, 1, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_state("rst_mid");
    m_sc = '0; m_fc = '0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) step("after_rst", I0, EA, F0, 0, 0);

    // saturation of both counters
    for (int k = 0; k < 20; k++) step("sat_stall", IC, EN, F0, 0, 0);
    for (int k = 0; k < 20; k++) step("sat_flush", BR, EA, FI, 0, 0);
    step("sat_end", I0, EA, F0, 0, 0);
    @(negedge clk); #1;
    chk("sat.scnt", 32'(stall_cnt), 32'(CMAX));
    chk("sat.fcnt", 32'(flush_cnt), 32'(CMAX));
    chk("sb_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
